// File: rtl/mem_wb_if.sv
// MEM/WB pipeline-register bundle: MEM-stage controls and payload in,
// write-back port and retire counter out.
interface mem_wb_if;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [2:0]  in_reg_op;
    logic [2:0]  in_wb_addr;
    logic [1:0]  in_wb_sel;
    logic [15:0] in_alu_data;
    logic [15:0] in_mem_data;
    logic [15:0] in_pc_plus1;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  reg_op;
    logic        wb_valid;
    logic [15:0] retire_cnt;

    // MEM-stage side: drives the slot, observes the write-back port.
    modport master (
        output stall, flush, in_valid, in_reg_op, in_wb_addr, in_wb_sel,
               in_alu_data, in_mem_data, in_pc_plus1,
        input  wb_addr, wb_data, reg_op, wb_valid, retire_cnt
    );

    // Pipeline register side.
    modport slave (
        input  stall, flush, in_valid, in_reg_op, in_wb_addr, in_wb_sel,
               in_alu_data, in_mem_data, in_pc_plus1,
        output wb_addr, wb_data, reg_op, wb_valid, retire_cnt
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. All outputs come straight from flops, so the
// register file (writing on the falling edge) sees a stable value for the
// whole cycle. Priority on each edge: reset, flush, stall, normal load.
module mem_wb_reg (
    input  logic     clk_50MHz,
    input  logic     rst,          // active low, synchronous
    mem_wb_if.slave  bus
);
    // Shared REG_OP target-class encodings; 6 and 7 are unused.
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_REG = 3'd1;
    localparam logic [2:0] OP_T   = 3'd2;
    localparam logic [2:0] OP_SP  = 3'd3;
    localparam logic [2:0] OP_IH  = 3'd4;
    localparam logic [2:0] OP_RA  = 3'd5;

    logic [2:0]  r_wb_addr;
    logic [15:0] r_wb_data;
    logic [2:0]  r_reg_op;
    logic        r_wb_valid;
    logic [15:0] r_retire_cnt;

    logic [15:0] w_sel_data;
    logic [2:0]  w_reg_op;

    // Write-back source mux; 11 aliases the ALU so every code is defined.
    always_comb begin
        w_sel_data = bus.in_alu_data;
        case (bus.in_wb_sel)
            2'b01:   w_sel_data = bus.in_mem_data;
            2'b10:   w_sel_data = bus.in_pc_plus1;
            default: w_sel_data = bus.in_alu_data;
        endcase
    end

    // Squash unused target-class encodings to NOP so the register file
    // never sees an op it cannot decode.
    always_comb begin
        w_reg_op = OP_NOP;
        case (bus.in_reg_op)
            OP_REG, OP_T, OP_SP, OP_IH, OP_RA: w_reg_op = bus.in_reg_op;
            default:                           w_reg_op = OP_NOP;
        endcase
    end

    // Stage register and retire counter, updated together so the count
    // always matches the instructions that reached write-back.
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            r_wb_addr    <= 3'd0;
            r_wb_data    <= 16'h0000;
            r_reg_op     <= OP_NOP;
            r_wb_valid   <= 1'b0;
            r_retire_cnt <= 16'h0000;
        end else if (bus.flush) begin
            r_wb_addr    <= 3'd0;
            r_wb_data    <= 16'h0000;
            r_reg_op     <= OP_NOP;
            r_wb_valid   <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                r_wb_addr    <= bus.in_wb_addr;
                r_wb_data    <= w_sel_data;
                r_reg_op     <= w_reg_op;
                r_wb_valid   <= 1'b1;
                r_retire_cnt <= r_retire_cnt + 16'd1;
            end else begin
                r_wb_addr    <= 3'd0;
                r_wb_data    <= 16'h0000;
                r_reg_op     <= OP_NOP;
                r_wb_valid   <= 1'b0;
            end
        end
        // stall without flush: everything holds, including the counter
    end

    assign bus.wb_addr    = r_wb_addr;
    assign bus.wb_data    = r_wb_data;
    assign bus.reg_op     = r_reg_op;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.retire_cnt = r_retire_cnt;
endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed bench for mem_wb_reg. Inputs change 1 ns after a rising edge and
// outputs are checked 1 ns after the next rising edge.
module tb_mem_wb_reg;
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_REG = 3'd1;
    localparam logic [2:0] OP_RA  = 3'd5;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    logic [22:0] obs;

    mem_wb_if bus();

    mem_wb_reg dut (
        .clk_50MHz (clk),
        .rst       (rst_n),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    task automatic drive(input logic st, input logic fl, input logic v,
                         input logic [2:0] op, input logic [2:0] addr,
                         input logic [1:0] sel, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [15:0] pc);
        bus.stall = st;  bus.flush = fl; bus.in_valid = v;
        bus.in_reg_op = op; bus.in_wb_addr = addr; bus.in_wb_sel = sel;
        bus.in_alu_data = alu; bus.in_mem_data = mem; bus.in_pc_plus1 = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        obs = {bus.reg_op, bus.wb_addr, bus.wb_data, bus.wb_valid};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, OP_REG, 3'd3, 2'b00, 16'h1111, 16'h2222, 16'h3333);
        tick();
        chk_cnt++;
        if (obs !== {OP_NOP, 3'd0, 16'h0000, 1'b0})
            $display("FAIL reset_outputs actual=%h required=%h", obs, {OP_NOP, 3'd0, 16'h0000, 1'b0});
        else pass_cnt++;
        chk_cnt++;
        if (bus.retire_cnt !== 16'h0000)
            $display("FAIL reset_cnt actual=%h required=0000", bus.retire_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, OP_NOP, 3'd0, 2'b00, 16'h0, 16'h0, 16'h0);
        $display("reset: outputs=%h cnt=%h", obs, bus.retire_cnt);
    endtask

    task automatic test_load_path();
        drive(1'b0, 1'b0, 1'b1, OP_REG, 3'd5, 2'b01, 16'h1234, 16'hBEEF, 16'h0007);
        tick();
        chk_cnt++;
        if (obs !== {OP_REG, 3'd5, 16'hBEEF, 1'b1})
            $display("FAIL load_path actual=%h required=%h", obs, {OP_REG, 3'd5, 16'hBEEF, 1'b1});
        else pass_cnt++;
        chk_cnt++;
        if (bus.retire_cnt !== 16'd1)
            $display("FAIL load_cnt actual=%h required=0001", bus.retire_cnt);
        else pass_cnt++;
        $display("load: outputs=%h cnt=%h", obs, bus.retire_cnt);
    endtask

    task automatic test_stall_flush();
        drive(1'b0, 1'b0, 1'b1, OP_RA, 3'd3, 2'b00, 16'h1234, 16'h5555, 16'h6666);
        tick();
        chk_cnt++;
        if (obs !== {OP_RA, 3'd3, 16'h1234, 1'b1})
            $display("FAIL ra_load actual=%h required=%h", obs, {OP_RA, 3'd3, 16'h1234, 1'b1});
        else pass_cnt++;
        // different live inputs during the stall must be ignored
        drive(1'b1, 1'b0, 1'b1, OP_REG, 3'd6, 2'b01, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if (obs !== {OP_RA, 3'd3, 16'h1234, 1'b1} || bus.retire_cnt !== 16'd2)
                $display("FAIL stall_hold[%0d] actual=%h/%h required=%h/0002", i, obs,
                         bus.retire_cnt, {OP_RA, 3'd3, 16'h1234, 1'b1});
            else pass_cnt++;
            $display("stall %0d: outputs=%h cnt=%h", i, obs, bus.retire_cnt);
        end
        drive(1'b1, 1'b1, 1'b1, OP_REG, 3'd6, 2'b01, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        tick();
        chk_cnt++;
        if (obs !== {OP_NOP, 3'd0, 16'h0000, 1'b0} || bus.retire_cnt !== 16'd2)
            $display("FAIL flush_over_stall actual=%h/%h required=%h/0002", obs,
                     bus.retire_cnt, {OP_NOP, 3'd0, 16'h0000, 1'b0});
        else pass_cnt++;
        $display("flush: outputs=%h cnt=%h", obs, bus.retire_cnt);
    endtask

    task automatic test_select_mux();
        drive(1'b0, 1'b0, 1'b1, OP_RA, 3'd7, 2'b10, 16'h9999, 16'h1111, 16'h0042);
        tick();
        chk_cnt++;
        if (obs !== {OP_RA, 3'd7, 16'h0042, 1'b1})
            $display("FAIL sel_pc actual=%h required=%h", obs, {OP_RA, 3'd7, 16'h0042, 1'b1});
        else pass_cnt++;
        drive(1'b0, 1'b0, 1'b1, OP_REG, 3'd2, 2'b11, 16'h7777, 16'h1111, 16'h0042);
        tick();
        chk_cnt++;
        if (obs !== {OP_REG, 3'd2, 16'h7777, 1'b1})
            $display("FAIL sel_alu11 actual=%h required=%h", obs, {OP_REG, 3'd2, 16'h7777, 1'b1});
        else pass_cnt++;
        drive(1'b0, 1'b0, 1'b1, 3'd3, 3'd1, 2'b00, 16'h4321, 16'h1111, 16'h0042);
        tick();
        chk_cnt++;
        if (obs !== {3'd3, 3'd1, 16'h4321, 1'b1} || bus.retire_cnt !== 16'd5)
            $display("FAIL sel_alu00 actual=%h/%h required=%h/0005", obs,
                     bus.retire_cnt, {3'd3, 3'd1, 16'h4321, 1'b1});
        else pass_cnt++;
        $display("select: outputs=%h cnt=%h", obs, bus.retire_cnt);
    endtask

    task automatic test_illegal_op();
        drive(1'b0, 1'b0, 1'b1, 3'd6, 3'd4, 2'b00, 16'hABCD, 16'h0, 16'h0);
        tick();
        chk_cnt++;
        if (obs !== {OP_NOP, 3'd4, 16'hABCD, 1'b1} || bus.retire_cnt !== 16'd6)
            $display("FAIL illegal_op6 actual=%h/%h required=%h/0006", obs,
                     bus.retire_cnt, {OP_NOP, 3'd4, 16'hABCD, 1'b1});
        else pass_cnt++;
        drive(1'b0, 1'b0, 1'b1, 3'd7, 3'd2, 2'b01, 16'h0, 16'h5A5A, 16'h0);
        tick();
        chk_cnt++;
        if (obs !== {OP_NOP, 3'd2, 16'h5A5A, 1'b1} || bus.retire_cnt !== 16'd7)
            $display("FAIL illegal_op7 actual=%h/%h required=%h/0007", obs,
                     bus.retire_cnt, {OP_NOP, 3'd2, 16'h5A5A, 1'b1});
        else pass_cnt++;
        drive(1'b0, 1'b0, 1'b1, OP_NOP, 3'd1, 2'b00, 16'h0F0F, 16'h0, 16'h0);
        tick();
        chk_cnt++;
        if (obs !== {OP_NOP, 3'd1, 16'h0F0F, 1'b1} || bus.retire_cnt !== 16'd8)
            $display("FAIL store_nop actual=%h/%h required=%h/0008", obs,
                     bus.retire_cnt, {OP_NOP, 3'd1, 16'h0F0F, 1'b1});
        else pass_cnt++;
        drive(1'b0, 1'b0, 1'b0, OP_REG, 3'd5, 2'b01, 16'h1111, 16'h2222, 16'h3333);
        tick();
        chk_cnt++;
        if (obs !== {OP_NOP, 3'd0, 16'h0000, 1'b0} || bus.retire_cnt !== 16'd8)
            $display("FAIL bubble actual=%h/%h required=%h/0008", obs,
                     bus.retire_cnt, {OP_NOP, 3'd0, 16'h0000, 1'b0});
        else pass_cnt++;
        $display("illegal/bubble: outputs=%h cnt=%h", obs, bus.retire_cnt);
    endtask

    task automatic test_counter_wrap();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, OP_REG, 3'd1, 2'b00, 16'h0001, 16'h0, 16'h0);
        for (int i = 0; i < 65535; i++) @(posedge clk);
        #1;
        chk_cnt++;
        if (bus.retire_cnt !== 16'hFFFF)
            $display("FAIL cnt_preload actual=%h required=FFFF", bus.retire_cnt);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.retire_cnt !== 16'h0000)
            $display("FAIL cnt_wrap actual=%h required=0000", bus.retire_cnt);
        else pass_cnt++;
        $display("wrap: cnt=%h", bus.retire_cnt);
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b0, 1'b0, 1'b1, OP_REG, 3'd6, 2'b01, 16'h0, 16'hCAFE, 16'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, OP_REG, 3'd2, 2'b00, 16'h2468, 16'h0, 16'h0);
        tick();
        chk_cnt++;
        if (obs !== {OP_REG, 3'd6, 16'hCAFE, 1'b1} || bus.retire_cnt !== 16'd1)
            $display("FAIL live_before_reset actual=%h/%h required=%h/0001", obs,
                     bus.retire_cnt, {OP_REG, 3'd6, 16'hCAFE, 1'b1});
        else pass_cnt++;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, OP_REG, 3'd2, 2'b00, 16'h2468, 16'h0, 16'h0);
        tick();
        chk_cnt++;
        if (obs !== {OP_NOP, 3'd0, 16'h0000, 1'b0} || bus.retire_cnt !== 16'd0)
            $display("FAIL reset_mid_stall actual=%h/%h required=%h/0000", obs,
                     bus.retire_cnt, {OP_NOP, 3'd0, 16'h0000, 1'b0});
        else pass_cnt++;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, OP_REG, 3'd2, 2'b00, 16'h2468, 16'h0, 16'h0);
        tick();
        chk_cnt++;
        if (obs !== {OP_REG, 3'd2, 16'h2468, 1'b1} || bus.retire_cnt !== 16'd1)
            $display("FAIL post_reset_load actual=%h/%h required=%h/0001", obs,
                     bus.retire_cnt, {OP_REG, 3'd2, 16'h2468, 1'b1});
        else pass_cnt++;
        $display("reset mid-stall: outputs=%h cnt=%h", obs, bus.retire_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, OP_NOP, 3'd0, 2'b00, 16'h0, 16'h0, 16'h0);
        #5;
        test_reset();
        test_load_path();
        test_stall_flush();
        test_select_mux();
        test_illegal_op();
        test_counter_wrap();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
